axis_acc_serializer: RTL



---
 rtl/acc_pkg.sv | 26 ++
 rtl/axis_acc_serializer.sv | 98 +++++++++
 2 files changed

// File: rtl/acc_pkg.sv
// Shared accumulator-path types: the wide engine beat, the per-member slice and
// the serializer state encoding.
package acc_pkg;

    localparam int unsigned COPIES         = 2;
    localparam int unsigned GROUPS         = 2;
    localparam int unsigned MEMBERS        = 8;
    localparam int unsigned UNITS          = 4;
    localparam int unsigned WORD_WIDTH_ACC = 32;
    localparam int unsigned TUSER_WIDTH    = 8;
    localparam int unsigned MEMBERS_W      = $clog2(MEMBERS);

    typedef logic [WORD_WIDTH_ACC-1:0] acc_word_t;

    typedef logic [COPIES-1:0][GROUPS-1:0][MEMBERS-1:0][UNITS-1:0][WORD_WIDTH_ACC-1:0]
        wide_beat_t;

    typedef logic [COPIES-1:0][GROUPS-1:0][UNITS-1:0][WORD_WIDTH_ACC-1:0] member_slice_t;

    // The state bit doubles as m_axis_tvalid.
    typedef enum logic {
        StEmpty = 1'b0,
        StShift = 1'b1
    } state_e;

endpackage

// File: rtl/axis_acc_serializer.sv
// Splits one wide accumulator beat into MEMBERS narrower AXI-Stream beats,
// member 0 first, with back-to-back handoff on the last member.
module axis_acc_serializer #(
    parameter int unsigned COPIES         = 2,
    parameter int unsigned GROUPS         = 2,
    parameter int unsigned MEMBERS        = 8,
    parameter int unsigned UNITS          = 4,
    parameter int unsigned WORD_WIDTH_ACC = 32,
    parameter int unsigned TUSER_WIDTH    = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,

    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [COPIES-1:0][GROUPS-1:0][MEMBERS-1:0][UNITS-1:0][WORD_WIDTH_ACC-1:0]
                                   s_axis_tdata,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [COPIES-1:0][GROUPS-1:0][UNITS-1:0][WORD_WIDTH_ACC-1:0]
                                   m_axis_tdata
);

    import acc_pkg::state_e;
    import acc_pkg::StEmpty;
    import acc_pkg::StShift;

    localparam int unsigned CntW = $clog2(MEMBERS);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   hold_last_q;
    logic [TUSER_WIDTH-1:0] hold_user_q;
    logic [COPIES-1:0][GROUPS-1:0][MEMBERS-1:0][UNITS-1:0][WORD_WIDTH_ACC-1:0] hold_data_q;

    logic last_member;
    logic accept;

    assign last_member   = (cnt_q == CntW'(MEMBERS - 1));
    assign m_axis_tvalid = (state_q == StShift);
    // Ready only looks at local state and m_axis_tready, never at s_axis_tvalid.
    assign s_axis_tready = ~m_axis_tvalid | (m_axis_tready & last_member);
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = StShift;
            cnt_d   = '0;
        end else if ((state_q == StShift) && m_axis_tready) begin
            if (last_member) begin
                state_d = StEmpty;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StEmpty;
            cnt_q       <= '0;
            hold_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                hold_last_q <= s_axis_tlast;
            end
        end
    end

    // Payload flops carry no reset; they are only observed while valid is set.
    always_ff @(posedge aclk) begin
        if (accept) begin
            hold_data_q <= s_axis_tdata;
            hold_user_q <= s_axis_tuser;
        end
    end

    for (genvar c = 0; c < COPIES; c++) begin : g_copy
        for (genvar g = 0; g < GROUPS; g++) begin : g_group
            for (genvar u = 0; u < UNITS; u++) begin : g_unit
                assign m_axis_tdata[c][g][u] = hold_data_q[c][g][cnt_q][u];
            end
        end
    end

    assign m_axis_tlast = hold_last_q & last_member;
    assign m_axis_tuser = hold_user_q;

endmodule
